// File: rtl/dot8_pkg.sv
// Shared types and constants for the dot8 accumulator slice.
package dot8_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  // A counter must be at least one bit wide, even when LEN is 1.
  function automatic int cnt_w(input int len);
    int w;
    w = $clog2(len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dot8_acc_if.sv
// Operand-pair input stream and result output stream of dot8_acc.
interface dot8_acc_if #(
  parameter int ACC_W = 24
);
  import dot8_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic            clr;
  logic            out_valid;
  logic            out_ready;
  logic [ACC_W-1:0] out_sum;
  logic            out_ovf;

  modport master (
    output in_valid, a, b, clr, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, a, b, clr, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/dot8_mul.sv
// Combinational unsigned 8x8 -> 16 shift-add multiplier (no pipeline register).
module dot8_mul
  import dot8_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] pp [OP_W];

  generate
    for (genvar gi = 0; gi < OP_W; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? (PROD_W'(a) << gi) : '0;
    end
  endgenerate

  always_comb begin
    prod = '0;
    for (int i = 0; i < OP_W; i++) begin
      prod = prod + pp[i];
    end
  end

endmodule

// File: rtl/dot8_acc.sv
// Dot-product accumulator: sums LEN products a*b, then holds the result for downstream.
// Optional DOT8_SAT_EN: accumulator clamps at 2^ACC_W-1 on overflow instead of wrapping.
module dot8_acc
  import dot8_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  dot8_acc_if.slave  bus
);

  localparam int               CNT_W = cnt_w(LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  state_t            state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [ACC_W-1:0]  sum_reg, sum_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ovf_reg, ovf_next;
  logic              out_ovf_reg, out_ovf_next;
  logic              valid_reg, valid_next;

  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum_full;
  logic              ovf_upd;
  logic [ACC_W-1:0]  acc_upd;

  dot8_mul u_mul (
    .a    (bus.a),
    .b    (bus.b),
    .prod (prod)
  );

  // One extra bit captures the carry out of the ACC_W-bit add.
  assign sum_full = {1'b0, acc_reg} + (ACC_W + 1)'(prod);
  assign ovf_upd  = ovf_reg | sum_full[ACC_W];

`ifdef DOT8_SAT_EN
  assign acc_upd = ovf_upd ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign acc_upd = sum_full[ACC_W-1:0];
`endif

  assign bus.in_ready  = (state_reg == ST_ACC);
  assign bus.out_valid = valid_reg;
  assign bus.out_sum   = sum_reg;
  assign bus.out_ovf   = out_ovf_reg;

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    ovf_next     = ovf_reg;
    sum_next     = sum_reg;
    out_ovf_next = out_ovf_reg;
    valid_next   = valid_reg;
    case (state_reg)
      ST_ACC: begin
        // clr wins over a simultaneous accept; that pair is dropped.
        if (bus.clr) begin
          acc_next = '0;
          cnt_next = '0;
          ovf_next = 1'b0;
        end else if (bus.in_valid) begin
          if (cnt_reg == LAST) begin
            sum_next     = acc_upd;
            out_ovf_next = ovf_upd;
            valid_next   = 1'b1;
            acc_next     = '0;
            cnt_next     = '0;
            ovf_next     = 1'b0;
            state_next   = ST_HOLD;
          end else begin
            acc_next = acc_upd;
            cnt_next = cnt_reg + CNT_W'(1);
            ovf_next = ovf_upd;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          valid_next = 1'b0;
          state_next = ST_ACC;
        end
      end
      default: state_next = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_ACC;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      sum_reg     <= '0;
      out_ovf_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      ovf_reg     <= ovf_next;
      sum_reg     <= sum_next;
      out_ovf_reg <= out_ovf_next;
      valid_reg   <= valid_next;
    end
  end

endmodule

// File: tb/tb_dot8_acc.sv
// Directed bench for dot8_acc: a 24-bit instance and an 18-bit instance for overflow cases.
module tb_dot8_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot8_acc_if #(.ACC_W(24)) bus0 ();
  dot8_acc_if #(.ACC_W(18)) bus1 ();

  dot8_acc #(.LEN(8), .ACC_W(24)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dot8_acc #(.LEN(8), .ACC_W(18)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

`ifdef DOT8_SAT_EN
  localparam logic [31:0] OVF18_ALL  = 32'd262143;
  localparam logic [31:0] OVF18_EDGE = 32'd262143;
`else
  localparam logic [31:0] OVF18_ALL  = 32'd258056;
  localparam logic [31:0] OVF18_EDGE = 32'd0;
`endif

  typedef struct packed {
    bit               sel;
    logic [7:0][7:0]  a;
    logic [7:0][7:0]  b;
    logic [31:0]      exp_sum;
    bit               exp_ovf;
  } vec_t;

  vec_t tbl [9];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit sel, input logic v, input logic [7:0] av,
                        input logic [7:0] bv, input logic c);
    if (sel) begin
      bus1.in_valid = v; bus1.a = av; bus1.b = bv; bus1.clr = c;
    end else begin
      bus0.in_valid = v; bus0.a = av; bus0.b = bv; bus0.clr = c;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus1.in_ready : bus0.in_ready;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? bus1.out_valid : bus0.out_valid;
  endfunction

  function automatic logic [31:0] osum(input bit sel);
    return sel ? 32'(bus1.out_sum) : 32'(bus0.out_sum);
  endfunction

  function automatic logic oovf(input bit sel);
    return sel ? bus1.out_ovf : bus0.out_ovf;
  endfunction

  // Sends n identical pairs back-to-back; returns with in_valid low.
  task automatic send_pairs(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                            input int n);
    int stalls = 0;
    for (int i = 0; i < n; i++) begin
      while (!rdy(sel) && stalls < 40) begin tick(); stalls++; end
      set_in(sel, 1'b1, av, bv, 1'b0);
      tick();
    end
    set_in(sel, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("send_stall", 32'(stalls), 32'd0);
  endtask

  // Full vector with out_ready held high; checks latency, value and 1-cycle pulse.
  task automatic run_vec(input int id, input vec_t v);
    int stalls = 0;
    for (int i = 0; i < 8; i++) begin
      while (!rdy(v.sel) && stalls < 40) begin tick(); stalls++; end
      set_in(v.sel, 1'b1, v.a[i], v.b[i], 1'b0);
      tick();
    end
    set_in(v.sel, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("vec_stall", 32'(stalls), 32'd0);
    chk("vec_valid_rise", 32'(vld(v.sel)), 32'd1);
    chk("vec_dead_ready", 32'(rdy(v.sel)), 32'd0);
    chk("vec_sum", osum(v.sel), v.exp_sum);
    chk("vec_ovf", 32'(oovf(v.sel)), 32'(v.exp_ovf));
    $display("vec %0d dut%0d sum=%0d ovf=%0d", id, v.sel, osum(v.sel), oovf(v.sel));
    tick();
    chk("vec_valid_pulse", 32'(vld(v.sel)), 32'd0);
    chk("vec_ready_back", 32'(rdy(v.sel)), 32'd1);
  endtask

  task automatic chk_reset(input bit sel, input string tag);
    chk({tag, "_in_ready"}, 32'(rdy(sel)), 32'd1);
    chk({tag, "_out_valid"}, 32'(vld(sel)), 32'd0);
    chk({tag, "_out_sum"}, osum(sel), 32'd0);
    chk({tag, "_out_ovf"}, 32'(oovf(sel)), 32'd0);
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 9; i++) tbl[i] = '0;
    for (int i = 0; i < 8; i++) begin
      tbl[0].a[i] = 8'(i + 1);  tbl[0].b[i] = 8'(i + 1);
      tbl[1].a[i] = 8'd255;     tbl[1].b[i] = 8'd255;
      tbl[2].a[i] = 8'(i + 1);  tbl[2].b[i] = 8'd10;
      tbl[4].a[i] = 8'd1;       tbl[4].b[i] = 8'd1;
      tbl[5].a[i] = 8'd255;     tbl[5].b[i] = 8'd255;
      tbl[6].a[i] = 8'(i + 1);  tbl[6].b[i] = 8'(i + 1);
      tbl[7].a[i] = (i < 4) ? 8'd255 : ((i == 4) ? 8'd45 : 8'd6);
      tbl[7].b[i] = (i < 4) ? 8'd255 : ((i == 4) ? 8'd45 : 8'd1);
    end
    tbl[4].a[0] = 8'd255; tbl[4].b[0] = 8'd255;
    tbl[8] = tbl[7];
    tbl[8].a[7] = 8'd7;
    tbl[0].exp_sum = 32'd204;     tbl[0].exp_ovf = 1'b0;
    tbl[1].exp_sum = 32'd520200;  tbl[1].exp_ovf = 1'b0;
    tbl[2].exp_sum = 32'd360;     tbl[2].exp_ovf = 1'b0;
    tbl[3].exp_sum = 32'd0;       tbl[3].exp_ovf = 1'b0;
    tbl[4].exp_sum = 32'd65032;   tbl[4].exp_ovf = 1'b0;
    tbl[5].exp_sum = OVF18_ALL;   tbl[5].exp_ovf = 1'b1;  tbl[5].sel = 1'b1;
    tbl[6].exp_sum = 32'd204;     tbl[6].exp_ovf = 1'b0;  tbl[6].sel = 1'b1;
    tbl[7].exp_sum = 32'd262143;  tbl[7].exp_ovf = 1'b0;  tbl[7].sel = 1'b1;
    tbl[8].exp_sum = OVF18_EDGE;  tbl[8].exp_ovf = 1'b1;  tbl[8].sel = 1'b1;

    set_in(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    set_in(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset(1'b0, "rst0");
    chk_reset(1'b1, "rst1");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    // Backpressure: result held for 5 cycles while the source keeps offering pairs.
    bus0.out_ready = 1'b0;
    send_pairs(1'b0, 8'd1, 8'd1, 8);
    chk("bp_valid", 32'(vld(1'b0)), 32'd1);
    chk("bp_sum", osum(1'b0), 32'd8);
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b1, 8'd9, 8'd9, 1'b0);
      tick();
      chk("bp_hold_sum", osum(1'b0), 32'd8);
      chk("bp_hold_ready", 32'(rdy(1'b0)), 32'd0);
      chk("bp_hold_valid", 32'(vld(1'b0)), 32'd1);
    end
    set_in(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    bus0.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(vld(1'b0)), 32'd0);
    chk("bp_release_ready", 32'(rdy(1'b0)), 32'd1);
    v = '0;
    for (int i = 0; i < 8; i++) begin v.a[i] = 8'd2; v.b[i] = 8'd2; end
    v.exp_sum = 32'd32;
    run_vec(100, v);

    // clr while a result is pending must not disturb it.
    bus0.out_ready = 1'b0;
    send_pairs(1'b0, 8'd3, 8'd3, 8);
    set_in(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    tick();
    chk("clr_hold_valid", 32'(vld(1'b0)), 32'd1);
    chk("clr_hold_sum", osum(1'b0), 32'd72);
    set_in(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    bus0.out_ready = 1'b1;
    tick();
    chk("clr_hold_release", 32'(vld(1'b0)), 32'd0);

    // clr together with the 4th accept discards that pair and the partial sum.
    send_pairs(1'b0, 8'd3, 8'd3, 3);
    set_in(1'b0, 1'b1, 8'd3, 8'd3, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("clr_acc_ready", 32'(rdy(1'b0)), 32'd1);
    chk("clr_acc_valid", 32'(vld(1'b0)), 32'd0);
    v = '0;
    for (int i = 0; i < 8; i++) begin v.a[i] = 8'd3; v.b[i] = 8'd3; end
    v.exp_sum = 32'd72;
    run_vec(101, v);

    // Asynchronous reset mid-vector, checked before any further clock edge.
    send_pairs(1'b0, 8'd1, 8'd1, 4);
    rst_n = 1'b0;
    #1;
    chk_reset(1'b0, "arst_mid");
    #1;
    rst_n = 1'b1;

    // Asynchronous reset while a result is pending.
    bus0.out_ready = 1'b0;
    send_pairs(1'b0, 8'd1, 8'd1, 8);
    chk("arst_hold_valid", 32'(vld(1'b0)), 32'd1);
    chk("arst_hold_sum", osum(1'b0), 32'd8);
    rst_n = 1'b0;
    #1;
    chk_reset(1'b0, "arst_hold");
    #1;
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    v = '0;
    for (int i = 0; i < 8; i++) begin v.a[i] = 8'd1; v.b[i] = 8'd1; end
    v.exp_sum = 32'd8;
    run_vec(102, v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
